// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq
//  Purpose  : 16x16 unsigned shift-add multiplier that time-shares an
//             external 16-bit ALU; 16 BUSY cycles per product.
//             MUL_SEQ_ZERO_BYPASS_EN: zero operands skip straight to DONE.
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] product,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_fun,
    input  logic [15:0] alu_r,
    input  logic        alu_c,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_ALU_ADD = 3'b000;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] acc_hi_q, acc_hi_d;
    logic [15:0] mplier_q, mplier_d;
    logic [4:0]  count_q, count_d;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_hi_d = 16'h0000;
                    count_d  = 5'd0;
                    state_d  = S_BUSY;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
                    if ((op_a == 16'h0000) || (op_b == 16'h0000)) begin
                        mplier_d = 16'h0000;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_BUSY: begin
                // Carry and sum shift right together; the sum LSB becomes a
                // finished product bit entering the top of the multiplier.
                acc_hi_d = {alu_c, alu_r[15:1]};
                mplier_d = {alu_r[0], mplier_q[15:1]};
                count_d  = count_q + 5'd1;
                if (count_q == 5'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= 16'h0000;
            acc_hi_q <= 16'h0000;
            mplier_q <= 16'h0000;
            count_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = {acc_hi_q, mplier_q};

    // ALU inputs are held at zero whenever no iteration is in progress.
    assign alu_fun = c_ALU_ADD;
    assign alu_a   = (state_q == S_BUSY) ? acc_hi_q : 16'h0000;
    assign alu_b   = ((state_q == S_BUSY) && mplier_q[0]) ? mcand_q : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq
//  Purpose  : Self-checking bench for mul_seq with an external ADD ALU model
//             and an arithmetic reference (a*b, fixed latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq;

`ifdef MUL_SEQ_ZERO_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] op_a = 16'h0000;
    logic [15:0] op_b = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] product;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_fun;
    logic [15:0] alu_r;
    logic        alu_c;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int last_wait;
    int responses;
    bit saw_carry;

    always #5 clk = ~clk;

    // Shared ALU: ADD on 3'b000, anything else yields a poison value.
    logic [16:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_r   = (alu_fun == 3'b000) ? alu_sum[15:0] : 16'hDEAD;
    assign alu_c   = (alu_fun == 3'b000) ? alu_sum[16]   : 1'b0;

    mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .product   (product),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_r     (alu_r),
        .alu_c     (alu_c),
        .busy      (busy)
    );

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit keep_valid);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        op_a      = a;
        op_b      = b;
        w = 0;
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, w);
        end
        @(posedge clk);
        #1;
        if (!keep_valid) req_valid = 1'b0;
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        last_wait = w;
    endtask

    task automatic finish_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [31:0] exp_p;
        int exp_lat;
        int lat;
        exp_p   = 32'(a) * 32'(b);
        exp_lat = (c_BYPASS && (a == 16'h0000 || b == 16'h0000)) ? 0 : 16;
        saw_carry = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            checks++;
            if (busy !== 1'b1 || req_ready !== 1'b0 || alu_fun !== 3'b000) begin
                errors++;
                $display("FAIL busy_phase: busy=%b req_ready=%b alu_fun=%b, required 1 0 000",
                         busy, req_ready, alu_fun);
            end
            saw_carry = saw_carry | alu_c;
            rsp_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency %h*%h: rsp_valid in cycle T+%0d, required T+%0d", a, b, lat + 1, exp_lat + 1);
        end
        checks++;
        if (product !== exp_p) begin
            errors++;
            $display("FAIL product %h*%h: got %h, required %h", a, b, product, exp_p);
        end
        checks++;
        if (alu_a !== 16'h0000 || alu_b !== 16'h0000 || alu_fun !== 3'b000) begin
            errors++;
            $display("FAIL alu_idle_done: alu_a=%h alu_b=%h alu_fun=%b, required 0 0 000", alu_a, alu_b, alu_fun);
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || product !== exp_p) begin
                errors++;
                $display("FAIL hold_stable: rsp_valid=%b req_ready=%b product=%h, required 1 0 %h",
                         rsp_valid, req_ready, product, exp_p);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        responses++;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake_idle: rsp_valid=%b req_ready=%b busy=%b, required 0 1 0",
                     rsp_valid, req_ready, busy);
        end
        rsp_ready = 1'($urandom);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        start_op(a, b, 1'b0);
        finish_op(a, b, hold);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || product !== 32'h0) begin
            errors++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b busy=%b product=%h, required 1 0 0 0",
                     req_ready, rsp_valid, busy, product);
        end
        checks++;
        if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_fun !== 3'b000) begin
            errors++;
            $display("FAIL reset_alu: alu_a=%h alu_b=%h alu_fun=%b, required 0 0 000", alu_a, alu_b, alu_fun);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        rsp_ready = 1'b1;
        run_op(16'd3, 16'd5, 0);
    endtask

    task automatic test_carry();
        run_op(16'hFFFF, 16'hFFFF, 1);
        checks++;
        if (saw_carry !== 1'b1) begin
            errors++;
            $display("FAIL carry_seen: alu_c observed=%b, required 1", saw_carry);
        end
    endtask

    task automatic test_backpressure();
        run_op(16'h1234, 16'h0100, 5);
    endtask

    task automatic test_reset_abort();
        start_op(16'hABCD, 16'h0F0F, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || product !== 32'h0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: req_ready=%b busy=%b product=%h rsp_valid=%b, required 1 0 0 0",
                     req_ready, busy, product, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || product !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: req_ready=%b busy=%b product=%h, required 1 0 0",
                     req_ready, busy, product);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_rsp: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
            end
        end
        run_op(16'd7, 16'd9, 0);
    endtask

    task automatic test_zero();
        run_op(16'h0000, 16'h1234, 0);
        run_op(16'h0055, 16'h0000, 2);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 5) == 0) a = 16'h0000;
            if ($urandom_range(0, 5) == 0) b = 16'h0000;
            run_op(a, b, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        int n0;
        qa = '{16'h0002, 16'hFFFF, 16'h8001, 16'h0000};
        qb = '{16'h0003, 16'h0001, 16'h7FFF, 16'h00FF};
        n0 = responses;
        rsp_ready = 1'b1;
        for (int i = 0; i < qa.size(); i++) begin
            start_op(qa[i], qb[i], 1'b1);
            if (i > 0) begin
                checks++;
                if (last_wait != 0) begin
                    errors++;
                    $display("FAIL b2b_accept: accept %0d cycles after return to IDLE, required 1", last_wait + 1);
                end
            end
            finish_op(qa[i], qb[i], 0);
        end
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (responses - n0 != qa.size() || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: responses=%0d busy=%b, required %0d 0", responses - n0, busy, qa.size());
        end
    endtask

    initial begin
        responses = 0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_abort();
        test_zero();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  requester presents operands.
REQ-004 SHALL have ports: req_ready  out  1  block can accept a request.
REQ-005 SHALL have ports: op_a  in  16  unsigned multiplicand.
REQ-006 SHALL have ports: op_b  in  16  unsigned multiplier.
REQ-007 SHALL have ports: rsp_valid  out  1  product available.
REQ-008 SHALL have ports: rsp_ready  in  1  consumer takes product.
REQ-009 SHALL have ports: product  out  32  unsigned op_a*op_b.
REQ-010 SHALL have ports: alu_a, alu_b  out  16 each  operands driven to shared 16-bit ALU.
REQ-011 SHALL have ports: alu_fun  out  3  ALU selector; 3'b000 = ADD.
REQ-012 SHALL have ports: alu_r  in  16, alu_c  in  1  ALU result and carry, combinational from alu_a/alu_b/alu_fun.
REQ-013 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 SHALL keep registers mcand[15:0], acc_hi[15:0], mplier[15:0] and count[4:0].
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 SHALL accept on a rising edge with req_valid & req_ready, latching mcand=op_a, mplier=op_b, acc_hi=0, count=0, and entering BUSY.
REQ-018 SHALL, in BUSY, drive alu_fun=3'b000, alu_a=acc_hi, alu_b=(mplier[0] ? mcand : 16'h0000).
REQ-019 SHALL, on each BUSY edge, load acc_hi <= {alu_c, alu_r[15:1]}, mplier <= {alu_r[0], mplier[15:1]}, count <= count+1.
REQ-020 SHALL leave BUSY for DONE on the edge where count==15, so BUSY lasts exactly 16 cycles.
REQ-021 SHALL drive product={acc_hi, mplier} in every state; the value is only meaningful while rsp_valid=1.
REQ-022 SHALL assert rsp_valid only in DONE and hold product stable until rsp_valid & rsp_ready.
REQ-023 SHALL move DONE->IDLE on the rsp_valid & rsp_ready edge.
REQ-024 SHALL NOT accept a new request in the DONE->IDLE cycle; req_ready rises the following cycle.
REQ-025 SHALL make latency accept edge T -> rsp_valid high in cycle T+17, with no backpressure.
REQ-026 SHALL drive alu_a=alu_b=0 and alu_fun=3'b000 in IDLE and DONE.
REQ-027 SHALL ignore req_valid, op_a and op_b outside IDLE.
REQ-028 SHALL ignore rsp_ready outside DONE.
REQ-029 SHALL produce a full 32-bit product with no overflow for all operand pairs.

Reset
REQ-030 SHALL, on rst high, immediately enter IDLE and clear mcand, acc_hi, mplier and count to 0.
REQ-031 SHALL hold outputs during reset at req_ready=1, rsp_valid=0, busy=0, product=0, alu_a=alu_b=0, alu_fun=3'b000.
REQ-032 SHALL, on reset during BUSY or DONE, abort the operation and discard the result; no rsp_valid is issued for it.

Configuration
REQ-033 SHALL provide macro MUL_SEQ_ZERO_BYPASS_EN.
REQ-034 SHALL, when MUL_SEQ_ZERO_BYPASS_EN is defined, go IDLE->DONE directly on an accepted request with op_a==0 or op_b==0, with acc_hi=mplier=0.
REQ-035 SHALL, in the MUL_SEQ_ZERO_BYPASS_EN bypass case, assert rsp_valid in cycle T+1 and never drive the ALU.
REQ-036 SHALL, when MUL_SEQ_ZERO_BYPASS_EN is undefined, process zero operands through the full 16-cycle BUSY sequence (latency T+17).

Verification
REQ-037 SHALL cover: op_a=3, op_b=5, rsp_ready=1 -> product=0x0000000F, rsp_valid first high exactly 17 cycles after accept.
REQ-038 SHALL cover: op_a=0xFFFF, op_b=0xFFFF -> product=0xFFFE0001, with alu_c=1 observed during BUSY.
REQ-039 SHALL cover: op_a=0x1234, op_b=0x0100, rsp_ready=0 for 5 cycles after rsp_valid -> product=0x00123400 stays stable, rsp_valid stays high, req_ready=0 throughout.
REQ-040 SHALL cover: rst pulse at BUSY count=7 -> next cycle req_ready=1, busy=0, product=0; a following request 7*9 returns 0x0000003F.
REQ-041 SHALL cover: op_a=0, op_b=0x1234 -> rsp_valid at T+1 with MUL_SEQ_ZERO_BYPASS_EN defined, at T+17 without; product=0 in both cases.
REQ-042 SHALL cover: back-to-back requests with req_valid held high -> second accept occurs exactly one cycle after DONE->IDLE, with no request dropped or duplicated.
